// File: rtl/peak_track_pkg.sv
// Shared definitions for the peak-hold tracker: sweep state encoding and default widths.
package peak_track_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_POS_W  = 32;
   localparam int DEF_AXES   = 2;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_HYST   = 4;

endpackage : peak_track_pkg

// File: rtl/peak_track_reg_if.sv
// Sweep control, sample/position stream and peak result bundle of the peak-hold register.
// Signal names are from the register's point of view (i_ = into it, o_ = out of it).
interface peak_track_reg_if
   import peak_track_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int POS_W  = DEF_POS_W,
   parameter int AXES   = DEF_AXES,
   parameter int CNT_W  = DEF_CNT_W
) ();

   logic                   i_start;
   logic                   i_stop;
   logic                   i_sample_valid;
   logic [DATA_W-1:0]      i_sample;
   logic [AXES*POS_W-1:0]  i_pos;

   logic [DATA_W-1:0]      o_peak_val;
   logic [AXES*POS_W-1:0]  o_peak_pos;
   logic [CNT_W-1:0]       o_peak_idx;
   logic [CNT_W-1:0]       o_sample_cnt;
   logic                   o_peak_valid;
   logic                   o_peak_upd;
   logic                   o_busy;
   logic                   o_done;

   // Sweep controller / sample source side
   modport master (
      output i_start, i_stop, i_sample_valid, i_sample, i_pos,
      input  o_peak_val, o_peak_pos, o_peak_idx, o_sample_cnt,
             o_peak_valid, o_peak_upd, o_busy, o_done
   );

   // Peak-hold register side
   modport slave (
      input  i_start, i_stop, i_sample_valid, i_sample, i_pos,
      output o_peak_val, o_peak_pos, o_peak_idx, o_sample_cnt,
             o_peak_valid, o_peak_upd, o_busy, o_done
   );

endinterface : peak_track_reg_if

// File: rtl/peak_cmp.sv
// Combinational capture decision: a sample replaces the stored peak when nothing is stored
// yet, or when it beats the stored peak by at least HYST. If peak + HYST no longer fits in
// DATA_W bits, no sample can ever reach it, so capture is blocked.
module peak_cmp
   import peak_track_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int HYST   = DEF_HYST
) (
   input  logic [DATA_W-1:0] i_sample,
   input  logic [DATA_W-1:0] i_peak_val,
   input  logic              i_peak_valid,
   output logic              o_capture
);

   logic [DATA_W:0] w_thresh;

   // Threshold carried one bit wider so its top bit flags an unreachable threshold.
   assign w_thresh  = {1'b0, i_peak_val} + (DATA_W + 1)'(HYST);
   assign o_capture = !i_peak_valid ||
                      (!w_thresh[DATA_W] && (i_sample >= w_thresh[DATA_W-1:0]));

endmodule : peak_cmp

// File: rtl/peak_track_reg.sv
// Peak-hold register for the tracker sweep. START clears the result and opens a sweep,
// valid samples are counted and compared against the stored peak, STOP closes the sweep
// with a one-cycle DONE pulse, and the result is then held in IDLE for the servo logic.
module peak_track_reg
   import peak_track_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int POS_W  = DEF_POS_W,
   parameter int AXES   = DEF_AXES,
   parameter int HYST   = DEF_HYST,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   peak_track_reg_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                 r_state;
   logic [DATA_W-1:0]      r_peak_val;
   logic [AXES*POS_W-1:0]  r_peak_pos;
   logic [CNT_W-1:0]       r_peak_idx;
   logic [CNT_W-1:0]       r_sample_cnt;
   logic                   r_peak_valid;
   logic                   r_peak_upd;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_capture;

   peak_cmp #(
      .DATA_W (DATA_W),
      .HYST   (HYST)
   ) u_cmp (
      .i_sample     (bus.i_sample),
      .i_peak_val   (r_peak_val),
      .i_peak_valid (r_peak_valid),
      .o_capture    (w_capture)
   );

   // Sweep FSM with the peak result, sample counter and status flags as registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: every register here drives an output, so all of them are reset; there is no
         // storage array whose reset could be skipped.
         r_state      <= ST_IDLE;
         r_peak_val   <= '0;
         r_peak_pos   <= '0;
         r_peak_idx   <= '0;
         r_sample_cnt <= '0;
         r_peak_valid <= 1'b0;
         r_peak_upd   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees this cycle's
         // register values (the index capture below relies on the pre-increment count).
         r_peak_upd <= 1'b0;
         r_done     <= 1'b0;
         if (bus.i_start) begin
            // START wins over STOP and over a sample in the same cycle.
            r_state      <= ST_SWEEP;
            r_busy       <= 1'b1;
            r_peak_val   <= '0;
            r_peak_pos   <= '0;
            r_peak_idx   <= '0;
            r_sample_cnt <= '0;
            r_peak_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_SWEEP: begin
                  if (bus.i_sample_valid) begin
                     if (r_sample_cnt != CNT_MAX) begin
                        r_sample_cnt <= r_sample_cnt + CNT_ONE;
                     end
                     if (w_capture) begin
                        r_peak_val   <= bus.i_sample;
                        r_peak_pos   <= bus.i_pos;
                        r_peak_idx   <= r_sample_cnt;
                        r_peak_valid <= 1'b1;
                        r_peak_upd   <= 1'b1;
                     end
                  end
                  if (bus.i_stop) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               ST_DONE: r_state <= ST_IDLE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.o_peak_val   = r_peak_val;
   assign bus.o_peak_pos   = r_peak_pos;
   assign bus.o_peak_idx   = r_peak_idx;
   assign bus.o_sample_cnt = r_sample_cnt;
   assign bus.o_peak_valid = r_peak_valid;
   assign bus.o_peak_upd   = r_peak_upd;
   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;

endmodule : peak_track_reg
